uart_tx_fifo: RTL and testbench

Byte FIFO between `packet_parser` and `uart_tx` in the UART ALU datapath. The parser emits response bytes with no backpressure, and `uart_tx` accepts one byte per frame time, so this block buffers the bursts. It presents a first-word-fall-through valid/ready stream to the transmitter. It reports fill level and latches a sticky overflow flag when a byte is dropped.

---
 rtl/uart_tx_fifo.sv | 72 +++++++
 tb/tb_uart_tx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through byte FIFO between packet_parser and uart_tx
module uart_tx_fifo #(
    parameter int DATA_WIDTH_P = 8,
    parameter int DEPTH_P      = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    input  logic [DATA_WIDTH_P-1:0]    data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [DATA_WIDTH_P-1:0]    data_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH_P):0]   count_o,
    output logic                       overflow_o,
    input  logic                       clear_overflow_i
);

    localparam int IDX_W = $clog2(DEPTH_P);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [DATA_WIDTH_P-1:0] mem [DEPTH_P];
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // The extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    assign pop  = !empty && ready_i;
    assign push = valid_i && (!full || pop);
    assign drop = valid_i && full && !pop;

    assign valid_o = !empty;
    assign ready_o = !full;
    assign count_o = wr_ptr - rd_ptr;
    assign data_o  = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // A drop wins over a same-cycle clear so no lost byte goes unreported.
            if (drop) begin
                overflow_o <= 1'b1;
            end else if (clear_overflow_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= data_i;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          ready_i;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic          clear_overflow_i;

    int errs   = 0;
    int checks = 0;

    logic [DW-1:0] exp_q[$];
    int            model_count = 0;
    logic          model_ovf   = 1'b0;

    uart_tx_fifo #(.DATA_WIDTH_P(DW), .DEPTH_P(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .valid_i          (valid_i),
        .data_i           (data_i),
        .ready_o          (ready_o),
        .valid_o          (valid_o),
        .data_o           (data_o),
        .ready_i          (ready_i),
        .count_o          (count_o),
        .overflow_o       (overflow_o),
        .clear_overflow_i (clear_overflow_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare outputs to the model, then predict the coming edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            exp_q.delete();
            model_count = 0;
            model_ovf   = 1'b0;
            check("mon_rst_valid", 32'(valid_o), 32'd0);
            check("mon_rst_count", 32'(count_o), 32'd0);
        end else begin
            logic pop_m, full_m, push_m, drop_m;
            check("mon_valid", 32'(valid_o), 32'(model_count > 0));
            check("mon_ready", 32'(ready_o), 32'(model_count != DEPTH));
            check("mon_count", 32'(count_o), 32'(model_count));
            check("mon_ovf", 32'(overflow_o), 32'(model_ovf));
            full_m = (model_count == DEPTH);
            pop_m  = (model_count > 0) && ready_i;
            push_m = valid_i && (!full_m || pop_m);
            drop_m = valid_i && full_m && !pop_m;
            if (pop_m) begin
                check("mon_data", 32'(data_o), 32'(exp_q.pop_front()));
            end
            if (push_m) begin
                exp_q.push_back(data_i);
            end
            model_count = model_count + int'(push_m) - int'(pop_m);
            if (drop_m)                model_ovf = 1'b1;
            else if (clear_overflow_i) model_ovf = 1'b0;
        end
    end

    task automatic drain(input string tag);
        ready_i = 1'b1;
        for (int k = 0; k < 3 * DEPTH && valid_o; k++) tick();
        check(tag, 32'(valid_o), 32'd0);
        check({tag, "_count"}, 32'(count_o), 32'd0);
        ready_i = 1'b0;
    endtask

    task automatic push_a5_after_reset();
        valid_i = 1'b1;
        data_i  = 8'hA5;
        tick();
        valid_i = 1'b0;
        check("a5_valid", 32'(valid_o), 32'd1);
        check("a5_data", 32'(data_o), 32'hA5);
        drain("a5_drain");
    endtask

    initial begin
        rst_ni = 1'b0;
        valid_i = 1'b0;
        data_i = '0;
        ready_i = 1'b0;
        clear_overflow_i = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        push_a5_after_reset();

        // Fill to the brim with the reader stalled
        for (int i = 0; i < DEPTH; i++) begin
            valid_i = 1'b1;
            data_i  = DW'(i);
            tick();
        end
        valid_i = 1'b0;
        check("fill_count", 32'(count_o), 32'(DEPTH));
        check("fill_ready", 32'(ready_o), 32'd0);

        // Drop while full, then clear
        valid_i = 1'b1;
        data_i  = 8'hEE;
        tick();
        valid_i = 1'b0;
        check("drop_ovf", 32'(overflow_o), 32'd1);
        check("drop_count", 32'(count_o), 32'(DEPTH));
        clear_overflow_i = 1'b1;
        tick();
        clear_overflow_i = 1'b0;
        check("clear_ovf", 32'(overflow_o), 32'd0);

        // Drop and clear together: the drop wins
        valid_i = 1'b1;
        data_i  = 8'hEE;
        clear_overflow_i = 1'b1;
        tick();
        valid_i = 1'b0;
        clear_overflow_i = 1'b0;
        check("dropclr_ovf", 32'(overflow_o), 32'd1);
        clear_overflow_i = 1'b1;
        tick();
        clear_overflow_i = 1'b0;
        check("dropclr_clear", 32'(overflow_o), 32'd0);

        // Push and pop together while full
        valid_i = 1'b1;
        data_i  = 8'h77;
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("fullpp_count", 32'(count_o), 32'(DEPTH));
        check("fullpp_ovf", 32'(overflow_o), 32'd0);
        check("fullpp_head", 32'(data_o), 32'h01);
        drain("fullpp_drain");

        // Wrap-around with a random stalling reader
        for (int i = 0; i < 40; i++) begin
            valid_i = 1'b1;
            data_i  = DW'(8'h80 + i);
            ready_i = ($urandom_range(0, 99) >= 30);
            tick();
        end
        valid_i = 1'b0;
        drain("wrap_drain");

        // Reset in the middle of a cycle with data buffered
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = DW'(8'h30 + i);
            tick();
        end
        valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd1);
        check("mid_rst_count", 32'(count_o), 32'd0);
        check("mid_rst_ovf", 32'(overflow_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        push_a5_after_reset();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
